// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

    localparam int STEPS_W     = 4;
    localparam int CMP_LAT_MAX = 3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        EVAL,
        DONE,
        ERR
    } sar_state_e;

    typedef enum logic [1:0] {
        HIT,
        GO_LOW,
        GO_HIGH,
        BAD
    } sar_act_e;

endpackage

// File: rtl/sar_flag_decode.sv
// Turns the comparator's bigger/smaller/same flags into one search action.
// With SAR_ERR_CHECK_EN defined, any non-one-hot flag set decodes to BAD.
module sar_flag_decode
    import sar_pkg::*;
(
    input  logic     cmp_bigger_i,
    input  logic     cmp_smaller_i,
    input  logic     cmp_same_i,
    output sar_act_e act_o
);

    always_comb begin
        act_o = GO_HIGH;
`ifdef SAR_ERR_CHECK_EN
        if (!$onehot({cmp_bigger_i, cmp_smaller_i, cmp_same_i})) begin
            act_o = BAD;
        end else if (cmp_same_i) begin
            act_o = HIT;
        end else if (cmp_bigger_i) begin
            act_o = GO_LOW;
        end
`else
        // All-zero flags fall through to GO_HIGH, i.e. treated as "smaller".
        if (cmp_same_i) begin
            act_o = HIT;
        end else if (cmp_bigger_i) begin
            act_o = GO_LOW;
        end
`endif
    end

endmodule

// File: rtl/sar_search_ctrl.sv
// Binary-search controller driving a guess into an external magnitude comparator.
// Optional SAR_ERR_CHECK_EN: inconsistent flags or an emptied range end in ERR.
//
// state | meaning
// IDLE  | after reset, waiting for start
// WAIT  | guess held while the comparator settles (CMP_LAT cycles)
// EVAL  | flags sampled, range narrowed, next guess formed
// DONE  | found valid, waiting for next start
// ERR   | comparator response inconsistent, waiting for next start
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CMP_LAT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cmp_bigger,
    input  logic               cmp_smaller,
    input  logic               cmp_same,
    output logic [WIDTH-1:0]   guess,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   found,
    output logic [STEPS_W-1:0] steps,
    output logic               err
);

    localparam logic [WIDTH:0]   HI_INIT  = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [STEPS_W-1:0] STEP_ONE = {{(STEPS_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       CNT_LOAD = (CMP_LAT > 0) ? 2'(CMP_LAT - 1) : 2'd0;
    localparam sar_state_e       STEP_ST  = (CMP_LAT > 0) ? WAIT : EVAL;

    sar_state_e         state_q, state_d;
    logic [WIDTH:0]     lo_q, lo_d;
    logic [WIDTH:0]     hi_q, hi_d;
    logic [WIDTH-1:0]   guess_q, guess_d;
    logic [WIDTH-1:0]   found_q, found_d;
    logic [STEPS_W-1:0] steps_q, steps_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [WIDTH:0]     guess_ext;
    logic [WIDTH:0]     sum;
    logic               advance;
    logic               take_err;
    sar_act_e           act;

    sar_flag_decode u_flag_decode (
        .cmp_bigger_i  (cmp_bigger),
        .cmp_smaller_i (cmp_smaller),
        .cmp_same_i    (cmp_same),
        .act_o         (act)
    );

    assign guess_ext = {1'b0, guess_q};

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        found_d  = found_q;
        steps_d  = steps_q;
        cnt_d    = cnt_q;
        sum      = '0;
        advance  = 1'b0;
        take_err = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = HI_INIT;
                    steps_d = '0;
                    guess_d = HI_INIT[WIDTH:1];
                    cnt_d   = CNT_LOAD;
                    state_d = STEP_ST;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = EVAL;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            EVAL: begin
                steps_d = steps_q + STEP_ONE;
                case (act)
                    HIT: begin
                        found_d = guess_q;
                        state_d = DONE;
                    end
                    GO_LOW: begin
                        // guess==lo means hi would drop below lo: range exhausted.
                        if (guess_ext == lo_q) begin
                            take_err = 1'b1;
                        end else begin
                            hi_d    = guess_ext - ONE_EXT;
                            advance = 1'b1;
                        end
                    end
                    GO_HIGH: begin
                        if (guess_ext == hi_q) begin
                            take_err = 1'b1;
                        end else begin
                            lo_d    = guess_ext + ONE_EXT;
                            advance = 1'b1;
                        end
                    end
                    default: take_err = 1'b1;
                endcase

                if (advance) begin
                    sum     = lo_d + hi_d;
                    guess_d = sum[WIDTH:1];
                    cnt_d   = CNT_LOAD;
                    state_d = STEP_ST;
                end

                if (take_err) begin
`ifdef SAR_ERR_CHECK_EN
                    found_d = '0;
                    state_d = ERR;
`else
                    found_d = guess_q;
                    state_d = DONE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= HI_INIT;
            guess_q <= '0;
            found_q <= '0;
            steps_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            guess_q <= guess_d;
            found_q <= found_d;
            steps_q <= steps_d;
            cnt_q   <= cnt_d;
        end
    end

    assign guess = guess_q;
    assign found = found_q;
    assign steps = steps_q;
    assign busy  = (state_q == WAIT) || (state_q == EVAL);
    assign done  = (state_q == DONE) || (state_q == ERR);
    assign err   = (state_q == ERR);

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: two instances (CMP_LAT=0 and CMP_LAT=2) against a behavioural comparator.
module tb_sar_search_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start0 = 1'b0, start2 = 1'b0;
    logic [W-1:0] tgt0 = '0, tgt2 = '0;
    logic         bad = 1'b0;

    logic [W-1:0] guess0, guess2, found0, found2;
    logic [3:0]   steps0, steps2;
    logic         busy0, busy2, done0, done2, err0, err2;
    logic         big0, sml0, same0, big2, sml2, same2;

    // Forcing "bad" makes the comparator claim bigger and smaller together.
    assign big0  = bad | (guess0 > tgt0);
    assign sml0  = bad | (guess0 < tgt0);
    assign same0 = !bad && (guess0 == tgt0);
    assign big2  = bad | (guess2 > tgt2);
    assign sml2  = bad | (guess2 < tgt2);
    assign same2 = !bad && (guess2 == tgt2);

    sar_search_ctrl #(.WIDTH(W), .CMP_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .cmp_bigger(big0), .cmp_smaller(sml0), .cmp_same(same0),
        .guess(guess0), .busy(busy0), .done(done0),
        .found(found0), .steps(steps0), .err(err0)
    );

    sar_search_ctrl #(.WIDTH(W), .CMP_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .cmp_bigger(big2), .cmp_smaller(sml2), .cmp_same(same2),
        .guess(guess2), .busy(busy2), .done(done2),
        .found(found2), .steps(steps2), .err(err2)
    );

    typedef struct packed {
        logic         busy;
        logic         done;
        logic [W-1:0] guess;
        logic [W-1:0] found;
        logic [3:0]   steps;
        logic         err;
    } obs_t;

    typedef struct {
        logic [W-1:0] found;
        logic [3:0]   steps;
        logic         err;
        int           lat;
    } exp_t;

    int checks   = 0;
    int failures = 0;

    exp_t         sb[$];
    logic [W-1:0] exp_g[$];
    logic [W-1:0] obs_g[$];

    function automatic obs_t snap(input int sel);
        if (sel != 0) return '{busy2, done2, guess2, found2, steps2, err2};
        return '{busy0, done0, guess0, found0, steps0, err0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference search: plain integer bisection against the comparator behaviour.
    task automatic model(input int t, input int lat, input bit bad_i);
        int lo = 0;
        int hi = (1 << W) - 1;
        int g;
        int n = 0;
        exp_t e;
        e.err   = 1'b0;
        e.found = '0;
        while (n < 16) begin
            g = (lo + hi) / 2;
            for (int r = 0; r <= lat; r++) exp_g.push_back(W'(g));
            n++;
            if (bad_i) begin
`ifdef SAR_ERR_CHECK_EN
                e.err   = 1'b1;
                e.found = '0;
                break;
`else
                if (g == lo) begin
                    e.found = W'(g);
                    break;
                end
                hi = g - 1;
`endif
            end else if (g == t) begin
                e.found = W'(g);
                break;
            end else if (g > t) begin
                hi = g - 1;
            end else begin
                lo = g + 1;
            end
        end
        e.steps = 4'(n);
        e.lat   = n * (lat + 1);
        sb.push_back(e);
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start2 = v; else start0 = v;
    endtask

    task automatic run_search(input int sel, input int t, input bit bad_i, input bit poke);
        int   lat = (sel != 0) ? 2 : 0;
        int   n = 0;
        int   ng;
        obs_t o;
        exp_t e;
        string pfx = $sformatf("s%0d_t%0d", sel, t);

        model(t, lat, bad_i);
        if (sel != 0) tgt2 = W'(t); else tgt0 = W'(t);
        bad = bad_i;
        obs_g.delete();

        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(sel, 1'b0);
        o = snap(sel);
        chk({pfx, "_done_drop"}, 32'(o.done), 32'd0);
        chk({pfx, "_busy_rise"}, 32'(o.busy), 32'd1);

        while (!o.done && n < 100) begin
            if (o.busy) obs_g.push_back(o.guess);
            if (poke && n == 2) set_start(sel, 1'b1);
            if (poke && n == 3) set_start(sel, 1'b0);
            @(negedge clk);
            n++;
            o = snap(sel);
        end
        set_start(sel, 1'b0);

        e = sb.pop_front();
        chk({pfx, "_latency"}, 32'(n), 32'(e.lat));
        chk({pfx, "_found"}, 32'(o.found), 32'(e.found));
        chk({pfx, "_steps"}, 32'(o.steps), 32'(e.steps));
        chk({pfx, "_err"}, 32'(o.err), 32'(e.err));
        chk({pfx, "_busy_end"}, 32'(o.busy), 32'd0);
        ng = exp_g.size();
        chk({pfx, "_nguess"}, 32'(obs_g.size()), 32'(ng));
        for (int i = 0; i < ng; i++) begin
            if (i < obs_g.size())
                chk($sformatf("%s_guess%0d", pfx, i), 32'(obs_g[i]), 32'(exp_g[i]));
        end
        exp_g.delete();

        @(negedge clk);
        o = snap(sel);
        chk({pfx, "_done_hold"}, 32'(o.done), 32'd1);
        chk({pfx, "_found_hold"}, 32'(o.found), 32'(e.found));
        bad = 1'b0;
    endtask

    initial begin
        obs_t o;

        #2;
        for (int s = 0; s < 2; s++) begin
            o = snap(s);
            chk($sformatf("rst%0d_guess", s), 32'(o.guess), 32'd0);
            chk($sformatf("rst%0d_busy", s), 32'(o.busy), 32'd0);
            chk($sformatf("rst%0d_done", s), 32'(o.done), 32'd0);
            chk($sformatf("rst%0d_err", s), 32'(o.err), 32'd0);
            chk($sformatf("rst%0d_found", s), 32'(o.found), 32'd0);
            chk($sformatf("rst%0d_steps", s), 32'(o.steps), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_search(0, 11, 1'b0, 1'b0);
        run_search(0, 0, 1'b0, 1'b0);
        run_search(0, 15, 1'b0, 1'b0);
        run_search(2, 5, 1'b0, 1'b0);
        run_search(2, 11, 1'b0, 1'b1);

        // Reset in the middle of the second step of a CMP_LAT=2 search.
        tgt2 = 4'd9;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_busy_before", 32'(busy2), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_guess", 32'(guess2), 32'd0);
        chk("midrst_busy", 32'(busy2), 32'd0);
        chk("midrst_done", 32'(done2), 32'd0);
        chk("midrst_steps", 32'(steps2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_search(2, 9, 1'b0, 1'b0);

        run_search(0, 3, 1'b1, 1'b0);
        run_search(0, 7, 1'b0, 1'b0);
        for (int t = 1; t < 16; t += 4) run_search(0, t, 1'b0, 1'b0);
        run_search(2, 14, 1'b0, 1'b0);
        run_search(2, 0, 1'b1, 1'b0);
        run_search(2, 8, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
